// File: rtl/scan_decoder.sv
// N-to-2^N one-hot decoder with registered outputs: DECODE mode latches a valid-qualified
// index, SCAN mode walks a single one-hot bit with a programmable dwell per position.
module scan_decoder #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [N-1:0]       inp,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    out_sel,
    output logic               out_valid,
    output logic [N-1:0]       index,
    output logic               wrap
);

    localparam int OUTS = 2**N;
    localparam logic [OUTS-1:0] SEL_FIRST = OUTS'(1);

    typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

    state_t             state;
    logic [DWELL_W-1:0] dwellCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_sel   <= '0;
            out_valid <= 1'b0;
            index     <= '0;
            wrap      <= 1'b0;
            dwellCnt  <= '0;
        end else if (!en) begin
            state     <= IDLE;
            out_sel   <= '0;
            out_valid <= 1'b0;
            index     <= '0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            // A fresh DECODE shows nothing until the first qualified index arrives.
            state <= DECODE;
            wrap  <= 1'b0;
            if (in_valid) begin
                out_sel   <= SEL_FIRST << inp;
                out_valid <= 1'b1;
                index     <= inp;
            end else if (state != DECODE) begin
                out_sel   <= '0;
                out_valid <= 1'b0;
                index     <= '0;
            end
        end else begin
            state <= SCAN;
            if (state != SCAN) begin
                out_sel   <= SEL_FIRST;
                out_valid <= 1'b1;
                index     <= '0;
                wrap      <= 1'b0;
                dwellCnt  <= dwell;
            end else if (dwellCnt != '0) begin
                dwellCnt <= dwellCnt - DWELL_W'(1);
                wrap     <= 1'b0;
            end else begin
                // Rotating keeps out_sel one-hot and in step with index without a decoder.
                out_sel   <= {out_sel[OUTS-2:0], out_sel[OUTS-1]};
                out_valid <= 1'b1;
                index     <= index + N'(1);
                wrap      <= (index == '1);
                dwellCnt  <= dwell;
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: N=1, 3 and 4 instances share one stimulus stream and are checked
// every cycle against an arithmetic model, with literal checks pinning the N=3 behaviour.
module tb_scan_decoder;

    logic       clk;
    logic       reset;
    logic       en;
    logic       mode;
    logic       inValid;
    logic [3:0] inpAll;
    logic [3:0] dwell;

    logic [1:0]  sel1;
    logic        valid1;
    logic [0:0]  idx1;
    logic        wrap1;
    logic [7:0]  sel3;
    logic        valid3;
    logic [2:0]  idx3;
    logic        wrap3;
    logic [15:0] sel4;
    logic        valid4;
    logic [3:0]  idx4;
    logic        wrap4;

    int compared   = 0;
    int mismatched = 0;

    int outsOf[3] = '{2, 8, 16};
    int mState[3];
    int mIdx[3];
    int mValid[3];
    int mWrap[3];
    int mLeft[3];
    bit modelStarted = 0;

    scan_decoder #(.N(1), .DWELL_W(4)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(inValid),
        .inp(inpAll[0:0]), .dwell(dwell),
        .out_sel(sel1), .out_valid(valid1), .index(idx1), .wrap(wrap1)
    );

    scan_decoder #(.N(3), .DWELL_W(4)) dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(inValid),
        .inp(inpAll[2:0]), .dwell(dwell),
        .out_sel(sel3), .out_valid(valid3), .index(idx3), .wrap(wrap3)
    );

    scan_decoder #(.N(4), .DWELL_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(inValid),
        .inp(inpAll), .dwell(dwell),
        .out_sel(sel4), .out_valid(valid4), .index(idx4), .wrap(wrap4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model tracks mode (0 idle, 1 decode, 2 scan), position, and remaining dwell per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mState[k] = 0; mIdx[k] = 0; mValid[k] = 0; mWrap[k] = 0; mLeft[k] = 0;
            end else if (!en) begin
                mState[k] = 0; mIdx[k] = 0; mValid[k] = 0; mWrap[k] = 0;
            end else if (!mode) begin
                mWrap[k] = 0;
                if (inValid) begin
                    mIdx[k] = int'(inpAll) % outsOf[k];
                    mValid[k] = 1;
                end else if (mState[k] != 1) begin
                    mIdx[k] = 0; mValid[k] = 0;
                end
                mState[k] = 1;
            end else begin
                if (mState[k] != 2) begin
                    mIdx[k] = 0; mValid[k] = 1; mWrap[k] = 0; mLeft[k] = int'(dwell);
                end else if (mLeft[k] > 0) begin
                    mLeft[k] = mLeft[k] - 1;
                    mWrap[k] = 0;
                end else begin
                    mIdx[k] = (mIdx[k] + 1) % outsOf[k];
                    mWrap[k] = (mIdx[k] == 0) ? 1 : 0;
                    mLeft[k] = int'(dwell);
                end
                mState[k] = 2;
            end
        end
        modelStarted = 1;
    end

    task automatic compareOne(input string tag, input int k, input logic [15:0] sel,
                              input logic vld, input logic [3:0] idx, input logic w);
        logic [15:0] expSel;
        expSel = (mValid[k] != 0) ? (16'd1 << mIdx[k]) : 16'd0;
        checkVal({tag, " out_sel"}, sel, expSel);
        checkVal({tag, " out_valid"}, {15'b0, vld}, 16'(mValid[k]));
        checkVal({tag, " index"}, {12'b0, idx}, 16'(mIdx[k]));
        checkVal({tag, " wrap"}, {15'b0, w}, 16'(mWrap[k]));
        checkVal({tag, " onehot0"}, {15'b0, $onehot0(sel)}, 16'd1);
        checkVal({tag, " sel_vs_index"}, sel, {15'b0, vld} << idx);
    endtask

    always @(negedge clk) begin
        if (modelStarted) begin
            compareOne("n1", 0, {14'b0, sel1}, valid1, {3'b0, idx1}, wrap1);
            compareOne("n3", 1, {8'b0, sel3}, valid3, {1'b0, idx3}, wrap3);
            compareOne("n4", 2, sel4, valid4, idx4, wrap4);
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic m, input logic v,
                                 input logic [3:0] i, input logic [3:0] d);
        reset   = r;
        en      = e;
        mode    = m;
        inValid = v;
        inpAll  = i;
        dwell   = d;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expSel,
                               input logic [2:0] expIdx, input logic expValid,
                               input logic expWrap);
        checkVal({name, " lit sel"}, {8'b0, sel3}, {8'b0, expSel});
        checkVal({name, " lit idx"}, {13'b0, idx3}, {13'b0, expIdx});
        checkVal({name, " lit valid"}, {15'b0, valid3}, {15'b0, expValid});
        checkVal({name, " lit wrap"}, {15'b0, wrap3}, {15'b0, expWrap});
    endtask

    initial begin
        logic [7:0] scanSeq[11] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02,
                                    8'h04, 8'h04, 8'h04, 8'h08, 8'h10};
        logic [2:0] scanIdx[11] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1,
                                    3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
        logic [7:0] walk;

        reset = 1'b1; en = 1'b1; mode = 1'b1; inValid = 1'b1; inpAll = 4'd5; dwell = 4'd3;
        @(negedge clk);

        // Reset dominates whatever else is driven.
        applyStimulus(1, 1, 1, 1, 4'd5, 4'd3);
        checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        checkVal("reset n1 sel", {14'b0, sel1}, 16'h0);
        checkVal("reset n4 sel", sel4, 16'h0);

        applyStimulus(0, 1, 0, 1, 4'd5, 4'd0);
        checkOutput("decode5", 8'h20, 3'd5, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, 0, 0, 4'd2, 4'd0);
            checkOutput("decode_hold", 8'h20, 3'd5, 1'b1, 1'b0);
        end

        // Walking one with dwell 0; the second 01 carries the wrap pulse.
        for (int c = 0; c < 9; c++) begin
            applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);
            walk = 8'h01 << (c % 8);
            checkOutput("scan_d0", walk, 3'(c % 8), 1'b1, (c == 8));
        end

        applyStimulus(0, 1, 0, 0, 4'd0, 4'd0);
        checkOutput("decode_entry", 8'h00, 3'd0, 1'b0, 1'b0);

        // Dwell 2, dropped to 0 partway through the third position.
        for (int c = 0; c < 11; c++) begin
            applyStimulus(0, 1, 1, 0, 4'd0, (c < 7) ? 4'd2 : 4'd0);
            checkOutput("scan_dwell", scanSeq[c], scanIdx[c], 1'b1, 1'b0);
        end

        applyStimulus(0, 0, 1, 0, 4'd0, 4'd0);
        checkOutput("en_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);
        checkOutput("scan_restart", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);
        checkOutput("scan_step", 8'h02, 3'd1, 1'b1, 1'b0);
        applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);
        checkOutput("reset_mid", 8'h00, 3'd0, 1'b0, 1'b0);

        for (int c = 0; c < 10000; c++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 15) != 0),
                          ($urandom_range(0, 31) < 24) ? mode : ~mode,
                          1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
